// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the default oversampling rate
// used by the receiver, transmitter and baud generator.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops reset to RST_VAL
// so the synchronized output starts at a known level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled, LSB-first, no parity; emits registered one-cycle done or
// frame-error pulses after the final stop-bit sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int SB_TICK    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_s_tick,
    input  logic                 i_rx,
    output logic                 o_rx_done_tick,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(max_int(OVERSAMPLE, SB_TICK));
    localparam int NB_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(SB_TICK - 1);
    localparam logic [NB_W-1:0]  DATA_LAST = NB_W'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     s_cnt_q, s_cnt_d;
    logic [NB_W-1:0]      n_cnt_q, n_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic                 rx_q;
    logic                 rx_s;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .d_i     (i_rx),
        .q_o     (rx_s)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rx_q    <= rx_s;
        end
    end

    // Start is sampled mid-bit; every later sample lands one full bit period further on.
    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rx_q && !rx_s) begin
                    state_d = START;
                    s_cnt_d = '0;
                end
            end
            START: begin
                if (i_s_tick) begin
                    if (s_cnt_q == HALF_LAST) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_cnt_d = '0;
                            n_cnt_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (i_s_tick) begin
                    if (s_cnt_q == BIT_LAST) begin
                        s_cnt_d = '0;
                        shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                        if (n_cnt_q == DATA_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (i_s_tick) begin
                    if (s_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                        if (rx_s) begin
                            dout_d = shreg_q;
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_rx_done_tick = done_q;
    assign o_frame_err    = err_q;
    assign o_dout         = dout_q;
    assign o_busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives framed bytes against a free-running tick and compares
// pulses and data with a frame-level model of what a UART receiver must report.
module tb_uart_rx;

    logic       i_clk;
    logic       i_rst_n;
    logic       i_s_tick;
    logic       i_rx;
    logic       o_rx_done_tick;
    logic [7:0] o_dout;
    logic       o_frame_err;
    logic       o_busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] obsDone[$];
    int         obsErr = 0;
    int         overlapCnt = 0;
    int         widePulseCnt = 0;
    logic       prevDone = 1'b0;
    logic       prevErr = 1'b0;

    logic [7:0] expDone[$];
    int         expErr = 0;
    logic [7:0] expDout = 8'h00;

    uart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16),
        .SB_TICK    (16)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_s_tick       (i_s_tick),
        .i_rx           (i_rx),
        .o_rx_done_tick (o_rx_done_tick),
        .o_dout         (o_dout),
        .o_frame_err    (o_frame_err),
        .o_busy         (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // One oversample tick every fourth clock.
    initial begin
        i_s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge i_clk);
            i_s_tick = 1'b1;
            @(negedge i_clk);
            i_s_tick = 1'b0;
        end
    end

    always @(negedge i_clk) begin
        if (o_rx_done_tick) obsDone.push_back(o_dout);
        if (o_frame_err) obsErr++;
        if (o_rx_done_tick && o_frame_err) overlapCnt++;
        if ((o_rx_done_tick && prevDone) || (o_frame_err && prevErr)) widePulseCnt++;
        prevDone = o_rx_done_tick;
        prevErr  = o_frame_err;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitTicks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge i_clk);
            if (i_s_tick) k++;
        end
    endtask

    task automatic idleGap(input int n);
        @(negedge i_clk);
        i_rx = 1'b1;
        if (n > 0) waitTicks(n);
    endtask

    // Sends start, 8 data bits LSB first and one stop bit; rstBit pulses reset late in that bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int rstBit);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk);
            i_rx = frame[i];
            if (i == rstBit) begin
                waitTicks(12);
                @(negedge i_clk);
                i_rst_n = 1'b0;
                @(negedge i_clk);
                i_rst_n = 1'b1;
                checkOutput("rstBusy", {31'd0, o_busy}, 32'd0);
                checkOutput("rstDout", {24'd0, o_dout}, 32'd0);
                waitTicks(4);
            end else if (i == 4) begin
                waitTicks(8);
                #1;
                checkOutput("busyMid", {31'd0, o_busy}, 32'd1);
                waitTicks(8);
            end else begin
                waitTicks(16);
            end
        end
    endtask

    task automatic checkCounts(input string tag);
        #1;
        checkOutput({tag, "_doneCnt"}, obsDone.size(), expDone.size());
        checkOutput({tag, "_errCnt"}, obsErr, expErr);
        checkOutput({tag, "_dout"}, {24'd0, o_dout}, {24'd0, expDout});
        checkOutput({tag, "_overlap"}, overlapCnt, 0);
        checkOutput({tag, "_wide"}, widePulseCnt, 0);
    endtask

    task automatic afterFrame(input string tag, input logic [7:0] data, input logic stopBit);
        if (stopBit) begin
            expDone.push_back(data);
            expDout = data;
        end else begin
            expErr++;
        end
        checkCounts(tag);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         gap;

        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_busy", {31'd0, o_busy}, 32'd0);
        checkOutput("rst_dout", {24'd0, o_dout}, 32'd0);
        checkOutput("rst_done", {31'd0, o_rx_done_tick}, 32'd0);
        checkOutput("rst_err", {31'd0, o_frame_err}, 32'd0);
        i_rst_n = 1'b1;
        idleGap(8);

        $display("[TB] frame 0xA5");
        applyStimulus(8'hA5, 1'b1, -1);
        afterFrame("t1", 8'hA5, 1'b1);
        idleGap(16);
        #1;
        checkOutput("t1_busyAfter", {31'd0, o_busy}, 32'd0);

        $display("[TB] start glitch");
        @(negedge i_clk);
        i_rx = 1'b0;
        waitTicks(4);
        @(negedge i_clk);
        i_rx = 1'b1;
        waitTicks(2);
        #1;
        checkOutput("t2_busyStart", {31'd0, o_busy}, 32'd1);
        waitTicks(4);
        #1;
        checkOutput("t2_busyIdle", {31'd0, o_busy}, 32'd0);
        checkCounts("t2");
        idleGap(16);

        $display("[TB] frame 0x3C with low stop");
        applyStimulus(8'h3C, 1'b0, -1);
        afterFrame("t3", 8'h3C, 1'b0);

        $display("[TB] line held low");
        waitTicks(640);
        #1;
        checkOutput("t4_busyLow", {31'd0, o_busy}, 32'd0);
        checkCounts("t4_low");
        idleGap(16);
        applyStimulus(8'h5A, 1'b1, -1);
        afterFrame("t4", 8'h5A, 1'b1);

        $display("[TB] back-to-back frames");
        applyStimulus(8'h00, 1'b1, -1);
        afterFrame("t5a", 8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1, -1);
        afterFrame("t5b", 8'hFF, 1'b1);
        applyStimulus(8'h81, 1'b1, -1);
        afterFrame("t5c", 8'h81, 1'b1);
        idleGap(16);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h77, 1'b1, 8);
        expDout = 8'h00;
        checkCounts("t6_rst");
        idleGap(16);
        applyStimulus(8'h12, 1'b1, -1);
        afterFrame("t6", 8'h12, 1'b1);
        idleGap(16);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            applyStimulus(b, stop, -1);
            afterFrame("rnd", b, stop);
            gap = stop ? int'($urandom_range(0, 20)) : 16 + int'($urandom_range(0, 8));
            idleGap(gap);
        end

        checkOutput("final_doneCnt", obsDone.size(), expDone.size());
        for (int i = 0; i < expDone.size(); i++) begin
            if (i < obsDone.size()) begin
                checkOutput($sformatf("order%0d", i), {24'd0, obsDone[i]}, {24'd0, expDone[i]});
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
